trap_ctrl: RTL
==============

// Module: trap_ctrl
// PURPOSE
//  Trap/return controller sitting upstream of the next-PC mux. Watches the EX stage for
//  ecall, illegal-instruction and mret, and accepts one async external interrupt line.
//  Produces sepc/scause plus one-cycle trap_req (selects NPC_INT) and mret_req (selects SEPC),
//  together with the pipeline flush. Single-level trap handling; no nesting.
// PARAMETERS
//  SYNC_STAGES    2      flops in the ext_irq synchronizer (>=2)
//  CAUSE_IRQ      32'h1  scause value for the external interrupt
//  CAUSE_ILLEGAL  32'h2  scause value for an illegal instruction
//  CAUSE_ECALL    32'h8  scause value for ecall
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   synchronous reset, active-high
//  pc_write      in   1   PC update enable; 0 = pipeline stalled
//  valid_ex      in   1   EX stage holds a real (non-bubble) instruction
//  pc_ex         in   32  PC of the instruction in EX
//  ecall_ex      in   1   EX instruction is ecall
//  illegal_ex    in   1   EX instruction failed decode
//  mret_ex       in   1   EX instruction is mret
//  ext_irq       in   1   asynchronous external interrupt, level
//  trap_req      out  1   combinational; NPC selects the handler vector
//  mret_req      out  1   combinational; NPC selects sepc
//  flush         out  1   combinational; kill IF/ID/EX this cycle
//  sepc          out  32  saved return PC, registered
//  scause        out  32  trap cause; bypassed from cause_nxt while trap_req=1
//  in_handler    out  1   registered; 1 while state==HANDLER
//  double_fault  out  1   sticky; ecall/illegal seen while in HANDLER
// BEHAVIOUR
//  Reset: state=IDLE; sepc=0, scause=0, irq_pend=0, ie=1, double_fault=0.
//    Combinational outputs are 0 in reset.
//  "commit" = pc_write & valid_ex. Nothing is taken or changed while pc_write=0; conditions
//    are re-evaluated every cycle.
//  ext_irq: SYNC_STAGES-flop sync, then a rising-edge detect sets irq_pend. irq_pend clears
//    only on the cycle the interrupt trap is taken. Edges arriving while pending coalesce.
//  FSM IDLE -> HANDLER when a trap is taken. Priority: illegal > ecall > irq (irq needs ie=1).
//    illegal: cause_nxt=CAUSE_ILLEGAL, sepc<=pc_ex+4.
//    ecall:   cause_nxt=CAUSE_ECALL,   sepc<=pc_ex+4.
//    irq:     cause_nxt=CAUSE_IRQ, sepc<=pc_ex; the EX instruction is flushed and later re-executed.
//    Take cycle: trap_req=1, flush=1, scause=cause_nxt (same cycle), ie<=0.
//    At the edge: scause reg <= cause_nxt, in_handler<=1.
//    mret_ex in IDLE is ignored (mret_req=0). sepc wraps mod 2^32.
//  FSM HANDLER -> IDLE on commit & mret_ex.
//    That cycle: mret_req=1, flush=1. At the edge: ie<=1, in_handler<=0.
//    sepc/scause hold their values.
//    ecall/illegal committed in HANDLER: no redirect, double_fault<=1 (sticky until rst),
//      state unchanged. mret has priority if flagged together.
//    irq edges stay latched in irq_pend; taken earliest 1 cycle after return.
//  Redirect latency: 0 cycles (combinational into NPC). State/regs update at the next edge.
//  trap_req and mret_req are never both 1.
//  rst mid-handler: immediate IDLE, all registers cleared, pending irq dropped.
// STRUCTURE
//  Shared package/define file: CAUSE_* codes, the NPC_INT opcode value, and FSM state
//    encoding (IDLE=1'b0, HANDLER=1'b1).
//  Sub-module irq_sync: SYNC_STAGES synchronizer + rising-edge pulse.
//    Sync flops are cleared by rst.
//  Remainder is one FSM + sepc/scause/ie/irq_pend/double_fault registers in trap_ctrl.
// TESTING
//  1 ecall at pc_ex=0x100, commit -> same cycle trap_req=1, flush=1, scause=8;
//    next cycle sepc=0x104, in_handler=1.
//  2 illegal+ecall together at 0x200 -> scause=2, sepc=0x204.
//    Then mret commit -> mret_req=1, in_handler=0 next cycle.
//  3 ext_irq pulse held 3 cycles, pc_ex=0x300 -> trap_req after sync latency, scause=1,
//    sepc=0x300. Assert irq again in HANDLER -> no trap; taken 1 cycle after mret.
//  4 pc_write=0 for 4 cycles with ecall pending -> no trap_req, regs stable;
//    fires on first pc_write=1.
//  5 ecall in HANDLER -> no redirect, double_fault=1, sepc unchanged.
//    mret in IDLE -> mret_req=0.
//  6 rst asserted in HANDLER with irq_pend=1 -> next cycle all outputs 0, ie=1,
//    no trap afterwards without a new edge. Also pc_ex=0xFFFFFFFC ecall -> sepc=0x0.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/return controller: cause codes, next-PC
// select opcodes and the controller state encoding.
package trap_ctrl_pkg;

  localparam logic [31:0] CAUSE_IRQ_DEF     = 32'h1;
  localparam logic [31:0] CAUSE_ILLEGAL_DEF = 32'h2;
  localparam logic [31:0] CAUSE_ECALL_DEF   = 32'h8;

  // Next-PC mux select values; trap_req selects NPC_INT, mret_req selects NPC_SEPC.
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_INT  = 2'd2;
  localparam logic [1:0] NPC_SEPC = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer for the asynchronous interrupt line followed by a
// single-cycle rising-edge pulse.
module trap_ctrl_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], async_in};
      prev <= sync[STAGES-1];
    end
  end

  assign pulse = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return controller feeding the next-PC mux: takes ecall, illegal and
// external-interrupt traps, returns on mret, and tracks sepc/scause.
module trap_ctrl #(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] CAUSE_IRQ     = 32'h1,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'h2,
  parameter logic [31:0] CAUSE_ECALL   = 32'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        valid_ex,
  input  logic [31:0] pc_ex,
  input  logic        ecall_ex,
  input  logic        illegal_ex,
  input  logic        mret_ex,
  input  logic        ext_irq,
  output logic        trap_req,
  output logic        mret_req,
  output logic        flush,
  output logic [31:0] sepc,
  output logic [31:0] scause,
  output logic        in_handler,
  output logic        double_fault
);

  import trap_ctrl_pkg::*;

  state_t      state;
  logic [31:0] scause_q;
  logic [31:0] cause_nxt;
  logic        ie;
  logic        irq_pend;
  logic        irq_edge;
  logic        commit;
  logic        take_sync;
  logic        take_irq;
  logic        ret;
  logic        fault;

  trap_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_irq),
    .pulse    (irq_edge)
  );

  // NOTE: every always_comb output gets a default first so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    commit    = pc_write & valid_ex & ~rst;
    take_sync = 1'b0;
    take_irq  = 1'b0;
    ret       = 1'b0;
    fault     = 1'b0;
    cause_nxt = CAUSE_IRQ;
    if (state == IDLE) begin
      take_sync = commit & (illegal_ex | ecall_ex);
      take_irq  = commit & ~illegal_ex & ~ecall_ex & irq_pend & ie;
      if (illegal_ex)    cause_nxt = CAUSE_ILLEGAL;
      else if (ecall_ex) cause_nxt = CAUSE_ECALL;
    end else begin
      ret   = commit & mret_ex;
      fault = commit & ~mret_ex & (illegal_ex | ecall_ex);
    end
  end

  assign trap_req   = take_sync | take_irq;
  assign mret_req   = ret;
  assign flush      = trap_req | mret_req;
  assign scause     = trap_req ? cause_nxt : scause_q;
  assign in_handler = (state == HANDLER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sepc         <= '0;
      scause_q     <= '0;
      ie           <= 1'b1;
      irq_pend     <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      // A fresh edge in the take cycle re-arms the pending flag.
      irq_pend <= irq_edge | (irq_pend & ~take_irq);
      if (trap_req) begin
        state    <= HANDLER;
        sepc     <= take_irq ? pc_ex : pc_ex + 32'd4;
        scause_q <= cause_nxt;
        ie       <= 1'b0;
      end else if (ret) begin
        state <= IDLE;
        ie    <= 1'b1;
      end
      if (fault) double_fault <= 1'b1;
    end
  end

endmodule
